// File: rtl/poly_vec_unit.sv
// Polynomial vector unit. Holds SLOTS polynomial buffers of N words each.
// Runs elementwise modular arithmetic between slots, LANES words per cycle,
// and moves whole polynomials in (LOAD) and out (STORE) over beat streams.
module poly_vec_unit #(
    parameter int W     = 64,
    parameter int N_LOG = 12,
    parameter int SLOTS = 4,
    parameter int LANES = 2,
    parameter int PIPE  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_op,
    input  logic [$clog2(SLOTS)-1:0] cmd_dst,
    input  logic [$clog2(SLOTS)-1:0] cmd_srca,
    input  logic [$clog2(SLOTS)-1:0] cmd_srcb,
    input  logic [W-1:0]             cmd_scalar,
    input  logic [W-1:0]             q,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [LANES*W-1:0]       ld_data,
    output logic                     st_valid,
    input  logic                     st_ready,
    output logic [LANES*W-1:0]       st_data
);

    localparam int N      = 1 << N_LOG;
    localparam int B      = N / LANES;
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int BEAT_W = $clog2(B);
    localparam int ADDR_W = SLOT_W + BEAT_W;
    localparam int DEPTH  = SLOTS * B;
    localparam int WIDE   = 2 * W + 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(B - 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_MAC   = 4'd3;
    localparam logic [3:0] OP_SMUL  = 4'd4;
    localparam logic [3:0] OP_COPY  = 4'd5;
    localparam logic [3:0] OP_LOAD  = 4'd8;
    localparam logic [3:0] OP_STORE = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_LOAD,
        S_STORE
    } state_t;

    state_t               state_q, state_d;
    logic [BEAT_W-1:0]    cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 st_valid_q, st_valid_d;

    // Command fields captured at acceptance.
    logic [3:0]           op_q;
    logic [SLOT_W-1:0]    dst_q, srca_q, srcb_q;
    logic [W-1:0]         scalar_q, q_q;

    // Arithmetic pipeline tracking: stage p holds a beat issued p+1 cycles ago.
    logic [PIPE-1:0]      vld_q;
    logic [BEAT_W-1:0]    pbeat_q [PIPE];

    logic                 issue, ld_we, last_write;
    logic [BEAT_W-1:0]    rd_a_beat, wr_beat;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr, addr_a, addr_b, addr_d;
    logic [LANES*W-1:0]   wr_data, res_comb, pipe_data;

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = ~cmd_ready;
    assign ld_ready   = (state_q == S_LOAD);
    assign st_valid   = st_valid_q;
    assign done       = done_q;
    assign err        = err_q;
    assign last_write = vld_q[PIPE-1] && (pbeat_q[PIPE-1] == LAST_BEAT);

    // Next-state logic: sequencing of RUN/DRAIN, LOAD beats and STORE handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        st_valid_d = st_valid_q;
        issue      = 1'b0;
        ld_we      = 1'b0;
        rd_a_beat  = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cnt_d      = '0;
                    st_valid_d = 1'b0;
                    case (cmd_op)
                        OP_ADD, OP_SUB, OP_MUL,
                        OP_MAC, OP_SMUL, OP_COPY: state_d = S_RUN;
                        OP_LOAD:                  state_d = S_LOAD;
                        OP_STORE:                 state_d = S_STORE;
                        default:                  err_d   = 1'b1;
                    endcase
                end
            end
            S_RUN: begin
                issue = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BEAT) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_write) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    ld_we = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_STORE: begin
                if (!st_valid_q) begin
                    st_valid_d = 1'b1;
                end else if (st_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d    = S_IDLE;
                        done_d     = 1'b1;
                        st_valid_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // Re-read the same beat while stalled so st_data holds steady.
                rd_a_beat = cnt_d;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            st_valid_q <= 1'b0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            st_valid_q <= st_valid_d;
            vld_q[0]   <= issue;
            for (int p = 1; p < PIPE; p++) begin
                vld_q[p] <= vld_q[p-1];
            end
        end
    end

    // Beat index travels alongside the pipeline valid to address the write.
    always_ff @(posedge clk) begin
        pbeat_q[0] <= cnt_q;
        for (int p = 1; p < PIPE; p++) begin
            pbeat_q[p] <= pbeat_q[p-1];
        end
    end

    // Capture command fields and modulus on acceptance.
    always_ff @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            op_q     <= cmd_op;
            dst_q    <= cmd_dst;
            srca_q   <= cmd_srca;
            srcb_q   <= cmd_srcb;
            scalar_q <= cmd_scalar;
            q_q      <= q;
        end
    end

    // LOAD and pipeline writes never overlap: LOAD only starts from IDLE.
    assign wr_en   = ld_we | vld_q[PIPE-1];
    assign wr_beat = ld_we ? cnt_q : pbeat_q[PIPE-1];
    assign wr_addr = {dst_q, wr_beat};
    assign wr_data = ld_we ? ld_data : pipe_data;
    assign addr_a  = {srca_q, rd_a_beat};
    assign addr_b  = {srcb_q, cnt_q};
    assign addr_d  = {dst_q, cnt_q};

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [W-1:0]    mem_a [DEPTH];
            logic [W-1:0]    mem_b [DEPTH];
            logic [W-1:0]    mem_d [DEPTH];
            logic [W-1:0]    rd_a_q, rd_b_q, rd_d_q;
            logic [W-1:0]    lane_res;
            logic [WIDE-1:0] wide;

            // Three mirrored RAMs give independent a, b and dst read ports.
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem_a[wr_addr] <= wr_data[gi*W +: W];
                    mem_b[wr_addr] <= wr_data[gi*W +: W];
                    mem_d[wr_addr] <= wr_data[gi*W +: W];
                end
                rd_a_q <= mem_a[addr_a];
                rd_b_q <= mem_b[addr_b];
                rd_d_q <= mem_d[addr_d];
            end

            // Exact wide intermediate followed by a single reduction mod q.
            always_comb begin
                wide = '0;
                case (op_q)
                    OP_ADD:  wide = WIDE'(rd_a_q) + WIDE'(rd_b_q);
                    OP_SUB:  wide = WIDE'(rd_a_q) + WIDE'(q_q) - WIDE'(rd_b_q);
                    OP_MUL:  wide = WIDE'(rd_a_q) * WIDE'(rd_b_q);
                    OP_MAC:  wide = WIDE'(rd_d_q) + WIDE'(rd_a_q) * WIDE'(rd_b_q);
                    OP_SMUL: wide = WIDE'(rd_a_q) * WIDE'(scalar_q);
                    default: wide = WIDE'(rd_a_q);
                endcase
                lane_res = (op_q == OP_COPY) ? rd_a_q : W'(wide % WIDE'(q_q));
            end

            assign res_comb[gi*W +: W] = lane_res;
            assign st_data[gi*W +: W]  = rd_a_q;
        end

        if (PIPE == 1) begin : g_pipe1
            assign pipe_data = res_comb;
        end else begin : g_pipen
            logic [LANES*W-1:0] data_q [PIPE-1];

            // Delay results so each beat lands exactly PIPE cycles after issue.
            always_ff @(posedge clk) begin
                data_q[0] <= res_comb;
                for (int p = 1; p < PIPE - 1; p++) begin
                    data_q[p] <= data_q[p-1];
                end
            end

            assign pipe_data = data_q[PIPE-2];
        end
    endgenerate

endmodule
